// File: rtl/vram_arbiter.sv
// Mode 13h VRAM arbiter: scanout owns even pixel slots in the
// active area, the CPU gets every other cycle; 2-cycle pixel pipe.
module vram_arbiter #(
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 200,
  parameter int V_OFFSET       = 40,
  parameter int VRAM_SIZE      = 64000
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        display_enable,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        vram_en,
  output logic        vram_we,
  output logic [15:0] vram_addr,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  pixel_index,
  output logic        pixel_valid
);

  localparam logic [15:0] LP_W    = 16'(DISPLAY_WIDTH);
  localparam logic [15:0] LP_H    = 16'(DISPLAY_HEIGHT);
  localparam logic [9:0]  LP_VOFF = 10'(V_OFFSET);
  localparam logic [15:0] LP_SIZE = 16'(VRAM_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_RDWAIT,
    S_ACK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [7:0]  r_pix;
  logic        r_de1;
  logic        r_de2;
  logic        r_disp_d;

  logic [15:0] w_row;
  logic [15:0] w_col;
  logic [15:0] w_disp_addr;
  logic        w_disp_slot;
  logic        w_oor;
  logic        w_cpu_go;

  // Scanout address; row*320 reduces to (row<<8)+(row<<6).
  // Rows past the framebuffer never claim a slot.
  assign w_row       = 16'((v_count - LP_VOFF) >> 1);
  assign w_col       = 16'(h_count >> 1);
  assign w_disp_addr = w_row * LP_W + w_col;
  assign w_disp_slot = display_enable & ~h_count[0] & (w_row < LP_H);
  assign w_oor       = (r_addr >= LP_SIZE);

  // CPU state register.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // CPU next state; the access fires only on a cycle scanout leaves free.
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_go    = 1'b0;
    unique case (r_state)
      S_IDLE:   if (cpu_req) w_state_nxt = S_PEND;
      S_PEND: begin
        if (!w_disp_slot) begin
          w_cpu_go    = 1'b1;
          w_state_nxt = r_we ? S_ACK : S_RDWAIT;
        end
      end
      S_RDWAIT: w_state_nxt = S_ACK;
      S_ACK:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the request on acceptance, capture read data one cycle after.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && cpu_req) begin
        r_we    <= cpu_we;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
      if (r_state == S_RDWAIT)
        r_rdata <= w_oor ? 8'h00 : vram_rdata;
    end
  end

  // Pixel pipe: grab the byte the cycle after a scanout read.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_de1    <= 1'b0;
      r_de2    <= 1'b0;
      r_disp_d <= 1'b0;
      r_pix    <= '0;
    end else begin
      r_de1    <= display_enable;
      r_de2    <= r_de1;
      r_disp_d <= w_disp_slot;
      if (r_disp_d) r_pix <= vram_rdata;
    end
  end

  // VRAM port mux: scanout first, then the pending CPU access.
  always_comb begin
    vram_en    = 1'b0;
    vram_we    = 1'b0;
    vram_addr  = '0;
    vram_wdata = '0;
    if (reset) begin
      vram_en = 1'b0;
    end else if (w_disp_slot) begin
      vram_en   = 1'b1;
      vram_addr = w_disp_addr;
    end else if (w_cpu_go) begin
      vram_en    = 1'b1;
      vram_we    = r_we & ~w_oor;
      vram_addr  = r_addr;
      vram_wdata = r_wdata;
    end
  end

  assign cpu_ack     = (r_state == S_ACK);
  assign cpu_rdata   = r_rdata;
  assign pixel_valid = r_de2;
  assign pixel_index = r_de2 ? r_pix : 8'h00;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM array, random CPU requester,
// transaction-level reference model, directed literal checks.
module tb_vram_arbiter;

  logic        clk_25mhz = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  h_count = '0;
  logic [9:0]  v_count = '0;
  logic        display_enable = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vram_en;
  logic        vram_we;
  logic [15:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = '0;
  logic [7:0]  pixel_index;
  logic        pixel_valid;

  vram_arbiter dut (
    .clk_25mhz      (clk_25mhz),
    .reset          (reset),
    .h_count        (h_count),
    .v_count        (v_count),
    .display_enable (display_enable),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_ack        (cpu_ack),
    .cpu_rdata      (cpu_rdata),
    .vram_en        (vram_en),
    .vram_we        (vram_we),
    .vram_addr      (vram_addr),
    .vram_wdata     (vram_wdata),
    .vram_rdata     (vram_rdata),
    .pixel_index    (pixel_index),
    .pixel_valid    (pixel_valid)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int ncmp = 0;
  int nmis = 0;

  logic [7:0] mem    [0:63999];
  logic [7:0] refmem [0:63999];
  logic [7:0] init0;

  // Physical VRAM: synchronous, one-cycle read; garbage when not read.
  always @(posedge clk_25mhz) begin
    if (vram_en && vram_we && vram_addr < 16'd64000)
      mem[vram_addr] <= vram_wdata;
    if (vram_en && !vram_we)
      vram_rdata <= (vram_addr < 16'd64000) ? mem[vram_addr] : 8'hA5;
    else
      vram_rdata <= 8'($urandom);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      if (nmis <= 60)
        $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  function automatic int daddr(input int v, input int h);
    return ((v - 40) / 2) * 320 + h / 2;
  endfunction

  // Reference model state: one outstanding CPU transaction.
  int         m_phase = 0;
  int         m_cnt = 0;
  bit         t_we;
  int         t_addr;
  logic [7:0] t_wd;
  logic [7:0] t_rd;
  logic [7:0] m_rhold = '0;
  bit         hde [2];
  logic [7:0] hpx [2];
  bit         disp;
  bit         e_en, e_we, e_ack;
  int         e_addr;
  logic [7:0] e_wd;

  always @(negedge clk_25mhz) begin
    if (reset) begin
      chk("rst_vram", {vram_en, vram_we, vram_addr, vram_wdata}, 0);
      chk("rst_cpu", {cpu_ack, cpu_rdata}, 0);
      chk("rst_pix", {pixel_valid, pixel_index}, 0);
      m_phase = 0;
      m_cnt   = 0;
      m_rhold = '0;
      hde[0] = 0; hde[1] = 0;
      hpx[0] = '0; hpx[1] = '0;
    end else begin
      disp = display_enable && !h_count[0];
      e_en = 0; e_we = 0; e_addr = 0; e_wd = '0;
      if (disp) begin
        e_en   = 1;
        e_addr = daddr(int'(v_count), int'(h_count));
      end else if (m_phase == 1) begin
        e_en   = 1;
        e_we   = t_we && t_addr < 64000;
        e_addr = t_addr;
        e_wd   = t_wd;
      end
      chk("vram_en", vram_en, e_en);
      if (e_en) begin
        chk("vram_we", vram_we, e_we);
        chk("vram_addr", vram_addr, e_addr);
        if (e_we) chk("vram_wdata", vram_wdata, e_wd);
      end
      e_ack = (m_phase == 2 && m_cnt == 0);
      if (e_ack && !t_we) m_rhold = t_rd;
      chk("cpu_ack", cpu_ack, e_ack);
      chk("cpu_rdata", cpu_rdata, m_rhold);
      chk("pixel_valid", pixel_valid, hde[1]);
      chk("pixel_index", pixel_index, hde[1] ? hpx[1] : 8'h00);
      hde[1] = hde[0];
      hpx[1] = hpx[0];
      hde[0] = display_enable;
      hpx[0] = display_enable ?
               refmem[daddr(int'(v_count), int'(h_count))] : 8'h00;
      if (m_phase == 2) begin
        if (m_cnt == 0) m_phase = 0;
        else            m_cnt--;
      end else if (m_phase == 1) begin
        if (!disp) begin
          t_rd = (t_addr < 64000) ? refmem[t_addr] : 8'h00;
          if (t_we && t_addr < 64000) refmem[t_addr] = t_wd;
          m_phase = 2;
          m_cnt   = t_we ? 0 : 1;
        end
      end else if (cpu_req) begin
        t_we    = cpu_we;
        t_addr  = int'(cpu_addr);
        t_wd    = cpu_wdata;
        m_phase = 1;
      end
    end
  end

  task automatic nx();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic sm();
    @(negedge clk_25mhz);
  endtask

  task automatic setc(input int h, input int v);
    h_count = 10'(h);
    v_count = 10'(v);
    display_enable = (h < 640 && v >= 40 && v < 440);
  endtask

  task automatic adv();
    int h = int'(h_count) + 1;
    int v = int'(v_count);
    if (h == 800) begin
      h = 0;
      v = (v == 524) ? 0 : v + 1;
    end
    setc(h, v);
  endtask

  logic        d_en, d_we;
  logic [15:0] d_addr;
  logic [7:0]  d_wd, d_rd;

  task automatic cpu_op(input logic we, input logic [15:0] a,
                        input logic [7:0] wd, input int lat,
                        input string nm);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    for (int c = 0; c < lat; c++) begin
      sm();
      if (c == 1) begin
        d_en = vram_en; d_we = vram_we;
        d_addr = vram_addr; d_wd = vram_wdata;
      end
      chk({nm, "_noack"}, cpu_ack, 0);
      nx();
    end
    sm();
    chk({nm, "_ack"}, cpu_ack, 1);
    d_rd = cpu_rdata;
    nx();
    cpu_req = 0;
    nx();
  endtask

  bit req_on = 0;
  int wcnt = 0;

  task automatic newreq();
    int r = int'($urandom_range(0, 7));
    cpu_req = 1;
    cpu_we  = 1'($urandom_range(0, 1));
    if (r == 0)      cpu_addr = 16'(64000 + $urandom_range(0, 1535));
    else if (r == 1) cpu_addr = 16'($urandom_range(0, 15));
    else             cpu_addr = 16'($urandom_range(0, 63999));
    cpu_wdata = 8'($urandom);
    wcnt = 0;
    req_on = 1;
  endtask

  task automatic rstep(input bit allow);
    logic a;
    sm();
    a = cpu_ack;
    nx();
    adv();
    if (req_on) begin
      if (a) begin
        if (allow && $urandom_range(0, 3) == 0) newreq();
        else begin cpu_req = 0; req_on = 0; end
      end else begin
        wcnt++;
        if (wcnt > 12) begin
          ncmp++; nmis++;
          $display("FAIL ack_timeout: got none in %0d cycles, want ack",
                   wcnt);
          cpu_req = 0; req_on = 0;
        end
      end
    end else if (allow && $urandom_range(0, 2) == 0) begin
      newreq();
    end
  endtask

  int rd_cnt;
  int cpu_h;
  bit dropn;

  initial begin
    for (int i = 0; i < 64000; i++) begin
      mem[i]    = 8'($urandom);
      refmem[i] = mem[i];
    end
    init0 = mem[0];
    setc(700, 0);
    repeat (3) nx();
    reset = 0;
    nx();

    // Reset in the middle of a pending CPU write, active area.
    setc(0, 100); nx(); adv(); nx(); adv();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0005; cpu_wdata = 8'h77;
    nx(); adv();
    #2 reset = 1;
    sm();
    chk("t1_rst_cpu", {cpu_ack, cpu_rdata, vram_en, vram_we}, 0);
    chk("t1_rst_bus", {vram_addr, vram_wdata, pixel_valid}, 0);
    chk("t1_rst_pix", pixel_index, 0);
    nx(); adv(); nx();
    setc(700, 0);
    nx();
    reset = 0;
    cpu_req = 0;
    for (int i = 0; i < 6; i++) begin
      sm();
      chk("t1_no_ack", cpu_ack, 0);
      nx();
    end
    cpu_op(1, 16'h0005, 8'h77, 2, "t1_rereq");

    // Blanking write then read-back.
    setc(700, 0);
    cpu_op(1, 16'h1234, 8'h5A, 2, "t2_wr");
    chk("t2_wr_strobe", {d_en, d_we}, 2'b11);
    chk("t2_wr_addr", d_addr, 16'h1234);
    chk("t2_wr_data", d_wd, 8'h5A);
    cpu_op(0, 16'h1234, 8'h00, 3, "t2_rd");
    chk("t2_rd_data", d_rd, 8'h5A);

    // Scanout addressing corners.
    setc(0, 40); sm();
    chk("t3_addr0", {vram_en, vram_we, vram_addr}, {2'b10, 16'd0});
    nx();
    setc(1, 41); sm();
    chk("t3_odd_h", vram_en, 0);
    nx();
    setc(2, 42); sm();
    chk("t3_addr321", {vram_en, vram_we, vram_addr}, {2'b10, 16'd321});
    nx();
    setc(638, 439); sm();
    chk("t3_addr63999", {vram_en, vram_addr}, {1'b1, 16'd63999});
    nx();
    setc(639, 439); nx();
    setc(640, 439); sm();
    chk("t3_pix640", {pixel_valid, pixel_index}, {1'b1, refmem[63999]});
    nx();
    setc(641, 439); sm();
    chk("t3_pix641", {pixel_valid, pixel_index}, {1'b1, refmem[63999]});
    nx();

    // CPU write raised on an even h inside an active line.
    rd_cnt = 0; cpu_h = -1; dropn = 0;
    for (int h = 0; h < 800; h++) begin
      setc(h, 100);
      if (h == 4) begin
        cpu_req = 1; cpu_we = 1;
        cpu_addr = 16'h0100; cpu_wdata = 8'h3C;
      end
      if (dropn) begin cpu_req = 0; dropn = 0; end
      sm();
      if (h < 640 && vram_en && !vram_we) rd_cnt++;
      if (vram_en && vram_we) cpu_h = h;
      if (cpu_ack) dropn = 1;
      nx();
    end
    chk("t4_disp_reads", rd_cnt, 320);
    chk("t4_cpu_slot_h", cpu_h, 5);

    // Out-of-range accesses.
    setc(700, 0);
    cpu_op(1, 16'd64000, 8'hFF, 2, "t5_oor_wr");
    chk("t5_oor_strobe", {d_en, d_we}, 2'b10);
    cpu_op(0, 16'hFFFF, 8'h00, 3, "t5_oor_rd");
    chk("t5_oor_rdata", d_rd, 8'h00);
    chk("t5_addr0", mem[0], init0);

    // Request held across an ack.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h2000; cpu_wdata = 8'h11;
    sm(); chk("t6_c0", cpu_ack, 0); nx();
    sm(); chk("t6_c1", cpu_ack, 0); nx();
    sm(); chk("t6_c2", cpu_ack, 1); nx();
    cpu_addr = 16'h2001; cpu_wdata = 8'h22;
    sm(); chk("t6_c3", cpu_ack, 0); nx();
    sm(); chk("t6_c4", cpu_ack, 0); nx();
    sm(); chk("t6_c5", cpu_ack, 1); nx();
    cpu_req = 0;
    nx();
    chk("t6_mem_a", mem[16'h2000], 8'h11);
    chk("t6_mem_b", mem[16'h2001], 8'h22);

    // Random traffic over real scan lines.
    for (int l = 0; l < 18; l++) begin
      if (l % 2 == 0) setc(0, int'($urandom_range(30, 445)));
      for (int i = 0; i < 800; i++) rstep(1);
    end
    for (int i = 0; i < 30; i++) rstep(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
